i4004_bus_master: RTL
=====================

Name: i4004_bus_master

Overview:
CPU-side initiator for the MCS-4 4-bit multiplexed bus. It generates the 8-phase instruction-cycle timing and SYNC. It drives the 12-bit fetch address on A1–A3 and captures the instruction byte on M1/M2. It asserts CM-ROM/CM-RAM and drives or samples X2/X3 data for I/O instructions on behalf of the execution core. It is the counterpart of the i4001/i4002 responders on the same bus.

Parameters:
OPR_IO, 4'hE, OPR nibble that marks an I/O/RAM instruction (CM asserted at M2)
RESET_PHASE, mcs4::X3, phase loaded on reset so the first post-reset cycle is A1

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
sync  out  1  high during X3; responders clear their phase counters on it
cm_rom  out  1  ROM command line
cm_ram  out  4  RAM bank command lines
dbus_in  in  4  bus data from responders (pre-ORed)
dbus_out  out  4  bus data driven by CPU; 0 when not driving
pc  in  12  next fetch address from core
ram_sel  in  4  CM-RAM bank mask (DCL state) from core
x_cm  in  1  assert CM lines at X2 (SRC / I/O execute)
x_drive  in  1  drive x_data2/x_data3 at X2/X3
x_rd  in  1  sample dbus_in at X2 (RDR/RDM/RD0-3)
x_data2  in  4  data for X2
x_data3  in  4  data for X3
phase  out  3  current mcs4::instr_cyc_t
instr  out  8  fetched byte {OPR,OPA}
instr_valid  out  1  one-cycle pulse, new instr available
io_rdata  out  4  nibble sampled at X2
io_rvalid  out  1  one-cycle pulse during X3

Behaviour:
- Phase register advances A1→A2→A3→M1→M2→X1→X2→X3→A1 every clk. There is no stall.
- sync = (phase==X3), combinational. Phase is 0 at A1, matching responder counters cleared on sync.
- Reset: phase<=X3, addr_q<=0, opr_q/opa_q<=0, x request regs<=0, instr<=0, instr_valid<=0, io_rdata<=0, io_rvalid<=0.
- Outputs during the reset cycle: sync=1, cm_rom=0, cm_ram=0, dbus_out=0.
- Address: at the X3 clock edge, addr_q<=pc. The pc value is used for the entire following cycle.
- dbus_out, combinational on phase:
  - A1: addr_q[3:0]
  - A2: addr_q[7:4]
  - A3: addr_q[11:8]
  - X2: x_data2 if xdrv_q
  - X3: x_data3 if xdrv_q
  - otherwise 0
- Fetch: at the M1 edge, opr_q<=dbus_in. At the M2 edge, opa_q<=dbus_in. At the X1 edge, instr<={opr_q,opa_q} and instr_valid=1 for exactly the X1 cycle.
- CM at M2: cm_rom = (opr_q==OPR_IO); cm_ram = (opr_q==OPR_IO) ? ram_sel : 0. Both are 0 in every other phase unless the X2 rule applies.
- X requests: x_cm, x_drive, x_rd and x_data2/x_data3 are sampled into registers at the X1 edge. Changes after X1 are ignored for that cycle.
- X2: cm_rom = xcm_q; cm_ram = xcm_q ? ram_sel : 0.
- Read: at the X2 edge, if xrd_q then io_rdata<=dbus_in and io_rvalid=1 for the X3 cycle only.
- If both xdrv_q and xrd_q are set, the drive wins: dbus_out is driven and the read still samples dbus_in. This is legal but is a core bug; flag it with an assertion.
- Reset mid-cycle: the phase restarts at X3. A partially fetched instr is discarded and instr_valid is not asserted for it.

Optional Feature:
I4004_BUS_HALT_EN
- Enabled: adds input halt, sampled at the X3 edge. While the sampled halt is 1:
  - addr_q is held instead of loading pc.
  - instr_valid and io_rvalid are suppressed.
  - The M2 CM assertion is suppressed, and x_cm/x_drive/x_rd are treated as 0.
  - Bus phases and sync continue unchanged, so responders stay aligned.
- Disabled: no halt port; behaviour as above.

Decomposition:
- Package mcs4 holds: instr_cyc_t (A1=0..X3=7), char_t, byte_t, addr_t (12-bit), ioram_opa_t, and constant OPR_IO.
- Sub-module i4004_phase_gen (phase counter, reset to RESET_PHASE, sync output). It is reusable by bus monitors.

Test Plan:
- Reset 3 cycles, release → sync=1 in the first cycle after release, then every 8th cycle; dbus_out=0 and cm_rom=0 during reset.
- pc=0x1A5 at X3, responder returns M1=0xD, M2=0x4 → dbus_out A1=5, A2=A, A3=1; instr=0xD4 with instr_valid high only in X1.
- Fetched OPR=0xE, ram_sel=4'b0010 → cm_rom=1 and cm_ram=0010 in M2 only; 0 in all other phases.
- x_cm=1, x_drive=1, x_data2=3, x_data3=7 held at X1 → X2: dbus_out=3, cm_rom=1; X3: dbus_out=7. Changing inputs during X2 has no effect.
- x_rd=1, dbus_in=0x9 at X2 → io_rdata=9, io_rvalid high in X3 only.
- rst asserted during M1 → next cycle phase=X3 and sync=1; no instr_valid for the aborted fetch; next A1 drives pc captured at that X3.

Source files
------------

// File: rtl/i4004_bus_master_pkg.sv
// MCS-4 bus definitions shared by the bus master, the phase generator and
// any bus monitor: instruction-cycle phase encoding, nibble/byte/address
// types, the I/O-RAM OPA opcodes and the OPR nibble that marks I/O/RAM
// instructions.
package mcs4;

    // Eight-phase instruction cycle; A1 is 0 so responders that clear their
    // counters on SYNC (high during X3) land on A1 with a zero count.
    typedef enum logic [2:0] {
        A1 = 3'd0,
        A2 = 3'd1,
        A3 = 3'd2,
        M1 = 3'd3,
        M2 = 3'd4,
        X1 = 3'd5,
        X2 = 3'd6,
        X3 = 3'd7
    } instr_cyc_t;

    typedef logic [3:0]  char_t;
    typedef logic [7:0]  byte_t;
    typedef logic [11:0] addr_t;

    // OPA field of the I/O and RAM instruction group (OPR == OPR_IO).
    typedef enum logic [3:0] {
        WRM = 4'h0,
        WMP = 4'h1,
        WRR = 4'h2,
        WPM = 4'h3,
        WR0 = 4'h4,
        WR1 = 4'h5,
        WR2 = 4'h6,
        WR3 = 4'h7,
        SBM = 4'h8,
        RDM = 4'h9,
        RDR = 4'hA,
        ADM = 4'hB,
        RD0 = 4'hC,
        RD1 = 4'hD,
        RD2 = 4'hE,
        RD3 = 4'hF
    } ioram_opa_t;

    localparam char_t OPR_IO = 4'hE;

    // Successor phase; X3 wraps back to A1.
    function automatic instr_cyc_t cyc_next(input instr_cyc_t p);
        return instr_cyc_t'(p + 3'd1);
    endfunction

endpackage

// File: rtl/i4004_bus_master_phase_gen.sv
// Free-running MCS-4 instruction-cycle phase counter with SYNC output.
// Reusable by bus masters and passive bus monitors alike.
module i4004_phase_gen
    import mcs4::*;
#(
    parameter instr_cyc_t RESET_PHASE = X3
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] phase,
    output logic       sync
);

    instr_cyc_t phase_r;

    // Phase register: loads RESET_PHASE on reset, otherwise steps every clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r <= RESET_PHASE;
        end else begin
            phase_r <= cyc_next(phase_r);
        end
    end

    assign phase = phase_r;
    assign sync  = (phase_r == X3);

endmodule

// File: rtl/i4004_bus_master.sv
// CPU-side initiator for the MCS-4 multiplexed 4-bit bus: drives the fetch
// address in A1-A3, captures the instruction byte in M1/M2, asserts CM-ROM /
// CM-RAM and drives or samples X2/X3 data for I/O instructions.
// Optional build macro I4004_BUS_HALT_EN adds a halt input sampled at X3
// that freezes the fetch address and masks all core-visible effects while
// keeping bus phases and SYNC running.

// Protocol checker: the core must not request a drive and a read in the
// same instruction cycle (drive wins on the bus, but it indicates a core bug).
module i4004_bus_master_chk (
    input logic clk,
    input logic rst,
    input logic xdrv,
    input logic xrd
);

    // Flag simultaneous drive and read requests latched at X1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            no_drive_and_read: assert (!(xdrv && xrd));
        end
    end

endmodule

module i4004_bus_master
    import mcs4::*;
#(
    parameter char_t      OPR_IO      = mcs4::OPR_IO,
    parameter instr_cyc_t RESET_PHASE = X3
) (
    input  logic        clk,
    input  logic        rst,
`ifdef I4004_BUS_HALT_EN
    input  logic        halt,
`endif
    output logic        sync,
    output logic        cm_rom,
    output logic [3:0]  cm_ram,
    input  logic [3:0]  dbus_in,
    output logic [3:0]  dbus_out,
    input  logic [11:0] pc,
    input  logic [3:0]  ram_sel,
    input  logic        x_cm,
    input  logic        x_drive,
    input  logic        x_rd,
    input  logic [3:0]  x_data2,
    input  logic [3:0]  x_data3,
    output logic [2:0]  phase,
    output logic [7:0]  instr,
    output logic        instr_valid,
    output logic [3:0]  io_rdata,
    output logic        io_rvalid
);

    logic [2:0] phase_s;
    logic       sync_s;
    instr_cyc_t cyc_s;
    logic       halt_s;

    addr_t      addr_r;
    char_t      opr_r;
    byte_t      instr_r;
    logic       instr_valid_r;
    logic       halt_r;
    logic       xcm_r;
    logic       xdrv_r;
    logic       xrd_r;
    char_t      xd2_r;
    char_t      xd3_r;
    char_t      io_rdata_r;
    logic       io_rvalid_r;

    logic       io_m2_s;
    char_t      dbus_out_s;
    logic       cm_rom_s;
    char_t      cm_ram_s;

`ifdef I4004_BUS_HALT_EN
    assign halt_s = halt;
`else
    assign halt_s = 1'b0;
`endif

    i4004_phase_gen #(
        .RESET_PHASE (RESET_PHASE)
    ) u_phase_gen (
        .clk   (clk),
        .rst   (rst),
        .phase (phase_s),
        .sync  (sync_s)
    );

    i4004_bus_master_chk u_chk (
        .clk  (clk),
        .rst  (rst),
        .xdrv (xdrv_r),
        .xrd  (xrd_r)
    );

    assign cyc_s = instr_cyc_t'(phase_s);

    // CM is asserted at M2 only for I/O/RAM instructions of a non-halted cycle.
    assign io_m2_s = (opr_r == OPR_IO) && !halt_r;

    // Per-phase bookkeeping: fetch address, instruction capture, X-request
    // latching and X2 read capture. Valid strobes are single-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r        <= 12'h000;
            opr_r         <= 4'h0;
            instr_r       <= 8'h00;
            instr_valid_r <= 1'b0;
            halt_r        <= 1'b0;
            xcm_r         <= 1'b0;
            xdrv_r        <= 1'b0;
            xrd_r         <= 1'b0;
            xd2_r         <= 4'h0;
            xd3_r         <= 4'h0;
            io_rdata_r    <= 4'h0;
            io_rvalid_r   <= 1'b0;
        end else begin
            instr_valid_r <= 1'b0;
            io_rvalid_r   <= 1'b0;
            case (cyc_s)
                M1: begin
                    opr_r <= dbus_in;
                end
                M2: begin
                    // OPA arrives now; the byte is presented during X1.
                    instr_r       <= {opr_r, dbus_in};
                    instr_valid_r <= !halt_r;
                end
                X1: begin
                    xcm_r  <= x_cm    && !halt_r;
                    xdrv_r <= x_drive && !halt_r;
                    xrd_r  <= x_rd    && !halt_r;
                    xd2_r  <= x_data2;
                    xd3_r  <= x_data3;
                end
                X2: begin
                    if (xrd_r) begin
                        io_rdata_r <= dbus_in;
                    end
                    io_rvalid_r <= xrd_r;
                end
                X3: begin
                    // The address for the next cycle is latched here and held
                    // for that whole cycle; a halted cycle re-fetches it.
                    halt_r <= halt_s;
                    if (!halt_s) begin
                        addr_r <= pc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Bus drive and command lines, decoded from the current phase.
    always_comb begin
        dbus_out_s = 4'h0;
        cm_rom_s   = 1'b0;
        cm_ram_s   = 4'h0;
        case (cyc_s)
            A1: dbus_out_s = addr_r[3:0];
            A2: dbus_out_s = addr_r[7:4];
            A3: dbus_out_s = addr_r[11:8];
            M2: begin
                if (io_m2_s) begin
                    cm_rom_s = 1'b1;
                    cm_ram_s = ram_sel;
                end else begin
                    cm_rom_s = 1'b0;
                    cm_ram_s = 4'h0;
                end
            end
            X2: begin
                if (xdrv_r) begin
                    dbus_out_s = xd2_r;
                end else begin
                    dbus_out_s = 4'h0;
                end
                if (xcm_r) begin
                    cm_rom_s = 1'b1;
                    cm_ram_s = ram_sel;
                end else begin
                    cm_rom_s = 1'b0;
                    cm_ram_s = 4'h0;
                end
            end
            X3: begin
                if (xdrv_r) begin
                    dbus_out_s = xd3_r;
                end else begin
                    dbus_out_s = 4'h0;
                end
            end
            default: begin
                dbus_out_s = 4'h0;
                cm_rom_s   = 1'b0;
                cm_ram_s   = 4'h0;
            end
        endcase
    end

    assign phase       = phase_s;
    assign sync        = sync_s;
    assign dbus_out    = dbus_out_s;
    assign cm_rom      = cm_rom_s;
    assign cm_ram      = cm_ram_s;
    assign instr       = instr_r;
    assign instr_valid = instr_valid_r;
    assign io_rdata    = io_rdata_r;
    assign io_rvalid   = io_rvalid_r;

endmodule
